moosic_pitch_detector: RTL and testbench

- Input-side counterpart of the moosic tone path: measures the period of an incoming square-wave audio signal and reports it as a clock-cycle count.
- Sits behind a top-level dedicated input pin. Its period_out feeds note lookup/display logic in the moosic top.
- Handles asynchronous input, filters glitches, and detects loss of signal.

---
 rtl/moosic_pitch_detector.sv | 130 +++++++++++++
 tb/tb_moosic_pitch_detector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moosic_pitch_detector.sv
// moosic_pitch_detector: measures the rising-edge to rising-edge period of an
// asynchronous square-wave input in clock cycles, rejecting too-short periods
// as glitches and flagging loss of signal when the counter saturates.
module moosic_pitch_detector #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MIN_PERIOD  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             period_strobe,
    output logic             glitch,
    output logic             too_slow
);

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_dly_q, sync_dly_d;
    logic                   rise_q, rise_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   strobe_q, strobe_d;
    logic                   glitch_q, glitch_d;
    logic                   slow_q, slow_d;

    // Synchronizer chain and registered rising-edge detect; runs regardless of
    // ena so that re-enabling never sees a stale edge.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], audio_in};
        sync_dly_d = sync_q[SYNC_STAGES-1];
        rise_d     = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
    end

    // Measurement FSM: next state, counter and output pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        glitch_d = 1'b0;
        slow_d   = 1'b0;
        if (!ena) begin
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    if (rise_q) begin
                        cnt_d   = CntOne;
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    // An edge on the saturating cycle still counts as a period.
                    if (rise_q) begin
                        cnt_d = CntOne;
                        if (cnt_q >= MinPeriod) begin
                            period_d = cnt_q;
                            strobe_d = 1'b1;
                            valid_d  = 1'b1;
                        end else begin
                            // Glitch edge becomes the new reference edge.
                            glitch_d = 1'b1;
                        end
                    end else if (cnt_q == CntMax) begin
                        slow_d  = 1'b1;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            glitch_q   <= 1'b0;
            slow_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            rise_q     <= rise_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            glitch_q   <= glitch_d;
            slow_q     <= slow_d;
        end
    end

    assign period_out    = period_q;
    assign period_valid  = valid_q;
    assign period_strobe = strobe_q;
    assign glitch        = glitch_q;
    assign too_slow      = slow_q;

endmodule

// File: tb/tb_moosic_pitch_detector.sv
// Directed bench for moosic_pitch_detector: a 16-bit instance for the period,
// glitch, reset and enable scenarios and an 8-bit instance for timeout.
module tb_moosic_pitch_detector;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        audio;
    logic [15:0] period_out;
    logic        period_valid;
    logic        period_strobe;
    logic        glitch;
    logic        too_slow;

    logic        ena8;
    logic        audio8;
    logic [7:0]  period8;
    logic        valid8;
    logic        strobe8;
    logic        glitch8;
    logic        slow8;

    int tests = 0;
    int fails = 0;

    // Event bookkeeping, updated once per clock in tick()
    int cyc        = 0;
    int strobe_cnt = 0;
    int glitch_cnt = 0;
    int slow_cnt   = 0;
    int first_per  = 0;
    int last_per   = 0;
    int multi_hot  = 0;
    int strobe8_cnt = 0;
    int glitch8_cnt = 0;
    int slow8_cnt   = 0;
    int last8       = 0;
    int slow8_cyc   = 0;
    int c0          = 0;

    moosic_pitch_detector #(
        .CNT_W      (16),
        .MIN_PERIOD (16),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .audio_in     (audio),
        .period_out   (period_out),
        .period_valid (period_valid),
        .period_strobe(period_strobe),
        .glitch       (glitch),
        .too_slow     (too_slow)
    );

    moosic_pitch_detector #(
        .CNT_W      (8),
        .MIN_PERIOD (16),
        .SYNC_STAGES(2)
    ) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena8),
        .audio_in     (audio8),
        .period_out   (period8),
        .period_valid (valid8),
        .period_strobe(strobe8),
        .glitch       (glitch8),
        .too_slow     (slow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and log any output pulses
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (period_strobe) begin
            if (strobe_cnt == 0) first_per = int'(period_out);
            strobe_cnt++;
            last_per = int'(period_out);
        end
        if (glitch) glitch_cnt++;
        if (too_slow) slow_cnt++;
        if ((int'(period_strobe) + int'(glitch) + int'(too_slow)) > 1) multi_hot++;
        if (strobe8) begin
            strobe8_cnt++;
            last8 = int'(period8);
        end
        if (glitch8) glitch8_cnt++;
        if (slow8) begin
            if (slow8_cnt == 0) slow8_cyc = cyc;
            slow8_cnt++;
        end
    endtask

    task automatic clear_counts();
        strobe_cnt = 0;
        glitch_cnt = 0;
        slow_cnt   = 0;
        first_per  = 0;
        last_per   = 0;
    endtask

    // One period of the main input: rises now, high for hi, low for lo clocks
    task automatic wave(input int hi, input int lo);
        audio = 1'b1;
        repeat (hi) tick();
        audio = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ena8   = 1'b1;
        audio  = 1'b0;
        audio8 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_period_out", 32'(period_out), 0);
        check("rst_valid", 32'(period_valid), 0);
        check("rst_strobe", 32'(period_strobe), 0);
        check("rst_glitch", 32'(glitch), 0);
        check("rst_too_slow", 32'(too_slow), 0);
        check("rst_period8", 32'(period8), 0);

        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (3) tick();
        clear_counts();

        // 100-clock wave: first edge gives no strobe, later edges report 100
        wave(50, 50);
        check("p100_first_edge_no_strobe", 32'(strobe_cnt), 0);
        check("p100_valid_before_2nd_edge", 32'(period_valid), 0);
        wave(50, 50);
        wave(50, 50);
        check("p100_strobe_count", 32'(strobe_cnt), 2);
        check("p100_last", 32'(last_per), 100);
        check("p100_period_out", 32'(period_out), 100);
        check("p100_valid", 32'(period_valid), 1);

        // Period change 100 -> 250
        clear_counts();
        wave(125, 125);
        wave(125, 125);
        check("p250_strobe_count", 32'(strobe_cnt), 2);
        check("p250_first", 32'(first_per), 100);
        check("p250_last", 32'(last_per), 250);

        // Glitch: accepted 100 period, then an edge 5 clocks later
        clear_counts();
        wave(50, 50);
        wave(50, 50);
        check("pre_glitch_last", 32'(last_per), 100);
        wave(2, 3);
        wave(47, 48);
        check("glitch_count", 32'(glitch_cnt), 1);
        check("glitch_period_out_held", 32'(period_out), 100);
        check("glitch_valid_held", 32'(period_valid), 1);
        check("glitch_no_extra_strobe", 32'(strobe_cnt), 3);
        wave(50, 50);
        check("post_glitch_period", 32'(last_per), 95);
        check("post_glitch_count", 32'(glitch_cnt), 1);

        // Asynchronous reset 40 clocks into a measurement
        audio = 1'b1;
        repeat (40) tick();
        audio = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_period_out", 32'(period_out), 0);
        check("mid_rst_valid", 32'(period_valid), 0);
        check("mid_rst_strobe", 32'(period_strobe), 0);
        check("mid_rst_glitch", 32'(glitch), 0);
        check("mid_rst_too_slow", 32'(too_slow), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        clear_counts();
        repeat (5) tick();
        wave(50, 50);
        check("post_rst_first_edge", 32'(strobe_cnt), 0);
        wave(50, 50);
        check("post_rst_strobe_count", 32'(strobe_cnt), 1);
        check("post_rst_period", 32'(last_per), 100);

        // Enable dropped for 10 cycles during a 60-clock wave
        wave(30, 30);
        wave(30, 30);
        wave(30, 30);
        check("p60_period_out", 32'(period_out), 60);
        clear_counts();
        ena   = 1'b0;
        audio = 1'b1;
        repeat (5) tick();
        check("dis_valid", 32'(period_valid), 0);
        check("dis_period_held", 32'(period_out), 60);
        repeat (5) tick();
        ena = 1'b1;
        repeat (20) tick();
        audio = 1'b0;
        repeat (30) tick();
        check("dis_no_strobe", 32'(strobe_cnt), 0);
        check("dis_no_glitch", 32'(glitch_cnt), 0);
        wave(30, 30);
        check("reen_first_edge", 32'(strobe_cnt), 0);
        wave(30, 30);
        check("reen_strobe_count", 32'(strobe_cnt), 1);
        check("reen_period", 32'(last_per), 60);
        check("reen_valid", 32'(period_valid), 1);
        check("reen_no_glitch", 32'(glitch_cnt), 0);

        // Timeout on the 8-bit instance: one 100 period, then input held low
        audio8 = 1'b1;
        repeat (50) tick();
        audio8 = 1'b0;
        repeat (50) tick();
        audio8 = 1'b1;
        c0 = cyc;
        repeat (50) tick();
        audio8 = 1'b0;
        repeat (150) tick();
        check("to_strobe8", 32'(strobe8_cnt), 1);
        check("to_period8", 32'(last8), 100);
        check("to_valid8_before", 32'(valid8), 1);
        check("to_no_slow_yet", 32'(slow8_cnt), 0);
        repeat (150) tick();
        check("to_slow_count", 32'(slow8_cnt), 1);
        check("to_slow_timing", 32'(slow8_cyc - c0), 259);
        check("to_valid8_after", 32'(valid8), 0);
        check("to_period8_held", 32'(period8), 100);
        audio8 = 1'b1;
        repeat (20) tick();
        check("to_idle_no_strobe", 32'(strobe8_cnt), 1);
        check("to_idle_no_glitch", 32'(glitch8_cnt), 0);

        check("one_hot_pulses", 32'(multi_hot), 0);
        check("main_no_timeout", 32'(slow_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
